// File: rtl/mod_fifo_8to1.sv
// Block-to-word FIFO. It accepts one 256-bit block (eight 32-bit words) per write
// and returns one 32-bit word per read, least-significant word first.
// Reads are first-word-fall-through, so the head word is always driven on outp_fifo.
// Handshake: a write is accepted when wr_fifo is high and fifo_full is low.
// A read is accepted when rd_fifo is high and outp_valid is high.
// Both conditions are judged on the level before the clock edge.
// A rejected request raises ovf (write) or udf (read) for exactly one cycle.
module mod_fifo_8to1 #(
    parameter int FIFO_SZ = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [255:0]               inp_fifo,
    input  logic                       wr_fifo,
    input  logic                       rd_fifo,
    output logic [31:0]                outp_fifo,
    output logic                       outp_valid,
    output logic                       fifo_empty,
    output logic                       fifo_full,
    output logic [$clog2(FIFO_SZ):0]   level,
    output logic                       ovf,
    output logic                       udf
);

    localparam int AW = $clog2(FIFO_SZ);
    localparam int LW = AW + 1;

    // The FIFO is full once fewer than eight free word slots remain.
    localparam logic [LW-1:0] FULL_THR = LW'(FIFO_SZ - 8);

    logic [31:0]   r_mem [FIFO_SZ];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_ovf;
    logic          r_udf;

    logic          w_full;
    logic          w_empty;
    logic          w_wr_acc;
    logic          w_rd_acc;
    logic [LW-1:0] w_level_nxt;

    // Status decodes and acceptance terms, all derived from the pre-edge level.
    always_comb begin
        w_empty     = (r_level == '0);
        w_full      = (r_level > FULL_THR);
        w_wr_acc    = wr_fifo && !w_full;
        w_rd_acc    = rd_fifo && !w_empty;
        w_level_nxt = r_level;
        if (w_wr_acc) begin
            w_level_nxt = w_level_nxt + LW'(8);
        end
        if (w_rd_acc) begin
            w_level_nxt = w_level_nxt - LW'(1);
        end
    end

    // Word storage. The write pointer always sits on an 8-word boundary,
    // so a block fills one aligned slot and never crosses the wrap point.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_SZ; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_acc) begin
            for (int i = 0; i < 8; i++) begin
                r_mem[{r_wr_ptr[AW-1:3], 3'(i)}] <= inp_fifo[32*i +: 32];
            end
        end
    end

    // Pointers, level and the one-cycle reject pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(8);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= w_level_nxt;
            r_ovf   <= wr_fifo && w_full;
            r_udf   <= rd_fifo && w_empty;
        end
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        outp_fifo  = r_mem[r_rd_ptr];
        outp_valid = !w_empty;
        fifo_empty = w_empty;
        fifo_full  = w_full;
        level      = r_level;
        ovf        = r_ovf;
        udf        = r_udf;
    end

endmodule

// File: tb/tb_mod_fifo_8to1.sv
// Testbench for mod_fifo_8to1.
// A queue of words models the FIFO. After every clock edge, each output is compared
// against values derived from that queue.
module tb_mod_fifo_8to1;

  localparam int FIFO_SZ = 64;
  localparam int LW      = $clog2(FIFO_SZ) + 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic [255:0]  inp_fifo;
  logic          wr_fifo;
  logic          rd_fifo;
  logic [31:0]   outp_fifo;
  logic          outp_valid;
  logic          fifo_empty;
  logic          fifo_full;
  logic [LW-1:0] level;
  logic          ovf;
  logic          udf;

  always #5 clk = ~clk;

  mod_fifo_8to1 #(.FIFO_SZ(FIFO_SZ)) dut (
    .clk        (clk),
    .reset      (reset),
    .inp_fifo   (inp_fifo),
    .wr_fifo    (wr_fifo),
    .rd_fifo    (rd_fifo),
    .outp_fifo  (outp_fifo),
    .outp_valid (outp_valid),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .level      (level),
    .ovf        (ovf),
    .udf        (udf)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_asserts = 0;
  int n_fails   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input logic exp_ovf, input logic exp_udf);
    int lvl;
    lvl = exp_q.size();
    check("level",      32'(level),      32'(lvl));
    check("outp_valid", 32'(outp_valid), 32'(lvl != 0));
    check("fifo_empty", 32'(fifo_empty), 32'(lvl == 0));
    check("fifo_full",  32'(fifo_full),  32'(lvl > FIFO_SZ - 8));
    check("ovf",        32'(ovf),        32'(exp_ovf));
    check("udf",        32'(udf),        32'(exp_udf));
    if (lvl != 0) check("outp_fifo", outp_fifo, exp_q[0]);
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of requests, then updates the model and checks the outputs.
  task automatic step(input logic wr, input logic rd, input logic [255:0] blk);
    logic wr_ok;
    logic rd_ok;
    @(negedge clk);
    wr_fifo  = wr;
    rd_fifo  = rd;
    inp_fifo = blk;
    wr_ok = wr && !(exp_q.size() > FIFO_SZ - 8);
    rd_ok = rd && (exp_q.size() != 0);
    @(posedge clk);
    #1;
    if (rd_ok) void'(exp_q.pop_front());
    if (wr_ok) for (int i = 0; i < 8; i++) exp_q.push_back(blk[32*i +: 32]);
    check_outputs(wr && !wr_ok, rd && !rd_ok);
  endtask

  function automatic logic [255:0] rand_blk();
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [255:0] seq_blk;
    int sent;

    reset    = 1'b1;
    wr_fifo  = 1'b0;
    rd_fifo  = 1'b0;
    inp_fifo = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_outputs(1'b0, 1'b0);
    check("reset_outp", outp_fifo, 32'h0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    check("idle_outp", outp_fifo, 32'h0);

    // A single block, then eight back-to-back reads.
    for (int i = 0; i < 8; i++) seq_blk[32*i +: 32] = 32'h1000_0000 + 32'(i);
    step(1'b1, 1'b0, seq_blk);
    check("first_word", outp_fifo, 32'h1000_0000);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0);
    check("drained_empty", 32'(fifo_empty), 32'h1);

    // Fill to capacity, overflow once, then read once.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, rand_blk());
    check("full_level", 32'(level), 32'(FIFO_SZ));
    step(1'b1, 1'b0, rand_blk());
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, '0);
    check("full_after_rd", 32'(fifo_full), 32'h1);

    // Simultaneous write and read at level 56 (accepted), then at 57 (rejected).
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, '0);
    check("level56", 32'(level), 32'(FIFO_SZ - 8));
    step(1'b1, 1'b1, rand_blk());
    check("level63", 32'(level), 32'(FIFO_SZ - 1));
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, '0);
    step(1'b1, 1'b1, rand_blk());
    check("level56_again", 32'(level), 32'(FIFO_SZ - 8));

    // Drain completely, then underflow.
    for (int i = 0; i < FIFO_SZ && exp_q.size() != 0; i++) step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);

    // Twenty random blocks with random interleaved reads, crossing the pointer wrap.
    sent = 0;
    for (int c = 0; c < 2000 && sent < 20; c++) begin
      logic wr;
      logic rd;
      wr = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      if (wr && !(exp_q.size() > FIFO_SZ - 8)) sent++;
      step(wr, rd, rand_blk());
    end
    check("blocks_sent", 32'(sent), 32'd20);
    for (int c = 0; c < 4 && exp_q.size() < 13; c++) step(1'b1, 1'b0, rand_blk());
    for (int c = 0; c < FIFO_SZ && exp_q.size() > 13; c++) step(1'b0, 1'b1, '0);
    check("level13", 32'(level), 32'd13);

    // Asynchronous reset during the drain.
    @(negedge clk);
    wr_fifo = 1'b0;
    rd_fifo = 1'b0;
    reset   = 1'b1;
    #1;
    exp_q.delete();
    check_outputs(1'b0, 1'b0);
    check("async_rst_outp", outp_fifo, 32'h0);
    @(posedge clk);
    #1;
    check_outputs(1'b0, 1'b0);
    check("rst_hold_outp", outp_fifo, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, rand_blk());
    step(1'b0, 1'b1, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
